mc_ctrl: RTL and testbench
==========================

# mc_ctrl

Multi-cycle control unit for the 32-bit RISC-V core. A Moore FSM sequences fetch, decode, execute, memory and writeback over a shared ALU/memory datapath. It drives the immediate extender's `imm_src`, the ALU operand muxes, the ALU operation, and the PC/IR/register-file/memory write strobes. It handles a memory-ready handshake and keeps a retired-instruction counter.

## Interface
- Parameters: none.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `op` in 7: instruction bits [6:0], taken from the IR.
- `funct3` in 3: instruction bits [14:12].
- `funct7b5` in 1: instruction bit 30.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory accepted the write, or has read data valid, this cycle.
- `pc_write` out 1: PC register enable.
- `adr_src` out 1: memory address select; 0 = PC, 1 = result bus.
- `mem_write` out 1: memory write request.
- `ir_write` out 1: IR and old-PC enable.
- `result_src` out 2: result bus select; 00 = ALUOut, 01 = Data, 10 = ALU result.
- `alu_src_a` out 2: ALU operand A select; 00 = PC, 01 = OldPC, 10 = regA.
- `alu_src_b` out 2: ALU operand B select; 00 = regB, 01 = ImmExt, 10 = constant 4.
- `imm_src` out 2: immediate format; 00 = I, 01 = S, 10 = B, 11 = J.
- `alu_control` out 3: ALU operation; 000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt.
- `reg_write` out 1: register-file write enable.
- `illegal` out 1: one-cycle pulse when an unsupported opcode is decoded.
- `instr_count` out 32: number of retired instructions.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, JAL, ALUWB, BEQ.
- Internal signals: `alu_op` (00 = add, 01 = sub, 10 = decode from funct fields), `pc_update`, `branch`.
- Output rule: `pc_write = pc_update | (branch & zero)`.
- Default for every output field not listed in a state: 0.
- FETCH:
  - Drives adr_src=0, a=00, b=10, alu_op=00, result_src=10.
  - `ir_write` and `pc_update` are asserted only while `mem_ready` is high.
  - `mem_ready`=1 → DECODE; otherwise stay in FETCH.
- DECODE:
  - Drives a=01, b=01, imm_src=10, alu_op=00 (branch target into ALUOut).
  - Next state by `op`: 0000011 (lw) or 0100011 (sw) → MEMADR; 0110011 → EXECR; 0010011 → EXECI; 1101111 → JAL; 1100011 → BEQ.
  - Any other opcode → FETCH with `illegal`=1.
- MEMADR: drives a=10, b=01, alu_op=00; imm_src=00 for lw, 01 for sw. lw → MEMREAD, sw → MEMWRITE.
- MEMREAD: drives adr_src=1, result_src=00. `mem_ready` → MEMWB; otherwise hold.
- MEMWB: drives result_src=01, reg_write=1 → FETCH.
- MEMWRITE: drives adr_src=1, result_src=00, mem_write=1 held until `mem_ready` → FETCH.
- EXECR: drives a=10, b=00, alu_op=10 → ALUWB.
- EXECI: drives a=10, b=01, imm_src=00, alu_op=10 → ALUWB.
- JAL: drives a=01, b=10, alu_op=00, result_src=00, imm_src=11, pc_update=1 → ALUWB.
- ALUWB: drives result_src=00, reg_write=1 → FETCH.
- BEQ: drives a=10, b=00, alu_op=01, result_src=00, imm_src=10, branch=1 → FETCH.
- ALU decode when alu_op=10, by `funct3`:
  - 000: sub if `op[5] & funct7b5`, else add.
  - 010: slt.
  - 110: or.
  - 111: and.
  - Any other funct3: add.
- `instr_count` increments by 1 on each of these transitions into FETCH: MEMWB→FETCH, ALUWB→FETCH, BEQ→FETCH, and MEMWRITE→FETCH (the last only when `mem_ready`=1).
  - An illegal opcode does not increment it.
  - The counter wraps from 0xFFFFFFFF to 0.

## Timing
- Reset:
  - State ← FETCH and `instr_count` ← 0 at the first rising edge with `reset`=1.
  - While `reset` is high, `pc_write`, `ir_write`, `mem_write`, `reg_write` and `illegal` are forced to 0.
  - Reset asserted mid-instruction (including while MEMWRITE is waiting on `mem_ready`) aborts the instruction on the next edge. No write strobe is asserted in that cycle.
- All outputs are combinational from the state register plus `op`, `funct3`, `funct7b5`, `zero` and `mem_ready`. There is no extra output register.
- Latency with `mem_ready` tied high:
  - lw: 5 cycles.
  - sw: 4 cycles.
  - R-type, I-type ALU, jal: 4 cycles.
  - beq: 3 cycles.
- Each low cycle of `mem_ready` in FETCH, MEMREAD or MEMWRITE adds exactly one cycle. Strobes stay stable while waiting.

## Structure
- Shared package `rv_ctrl_pkg`:
  - State enum.
  - Opcode constants: OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ.
  - imm_src encodings.
  - alu_control encodings.
  - Mux-select encodings.
- One sub-module, `alu_dec`: combinational; inputs alu_op, funct3, funct7b5, op[5]; output alu_control.

## Test plan
- Reset asserted for 2 cycles, then released with `mem_ready`=1 and op=0110011, funct3=000, funct7b5=1 → sequence FETCH, DECODE, EXECR, ALUWB. In EXECR, alu_control=001. In ALUWB, reg_write=1. `instr_count` = 1 afterwards.
- lw (op=0000011) with `mem_ready` low for 3 cycles in MEMREAD → imm_src=00 in MEMADR, adr_src=1 held for 4 cycles, reg_write pulses in MEMWB. Total 8 cycles.
- beq with zero=1 → pc_write=1 in BEQ, imm_src=10. Same instruction with zero=0 → pc_write=0. Both cases increment `instr_count`.
- jal → imm_src=11 in JAL with pc_write=1, then ALUWB reg_write=1.
- op=1111111 → `illegal` pulses in DECODE, next state FETCH, `instr_count` unchanged.
- `reset` asserted during MEMWRITE wait → mem_write=0 in that cycle, state FETCH next cycle. Separately, preload the counter path to 0xFFFFFFFF and retire one instruction → `instr_count` = 0.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RISC-V control path: FSM states,
// opcodes, mux selects, immediate formats and ALU operations.
package rv_ctrl_pkg;

  localparam int unsigned OP_W   = 7;
  localparam int unsigned F3_W   = 3;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned ALUC_W = 3;
  localparam int unsigned CNT_W  = 32;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_JAL,
    S_ALUWB,
    S_BEQ
  } state_t;

  localparam logic [OP_W-1:0] OP_LW  = 7'b0000011;
  localparam logic [OP_W-1:0] OP_SW  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_R   = 7'b0110011;
  localparam logic [OP_W-1:0] OP_I   = 7'b0010011;
  localparam logic [OP_W-1:0] OP_JAL = 7'b1101111;
  localparam logic [OP_W-1:0] OP_BEQ = 7'b1100011;

  localparam logic [SEL_W-1:0] IMM_I = 2'b00;
  localparam logic [SEL_W-1:0] IMM_S = 2'b01;
  localparam logic [SEL_W-1:0] IMM_B = 2'b10;
  localparam logic [SEL_W-1:0] IMM_J = 2'b11;

  localparam logic [ALUC_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALUC_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALUC_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALUC_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALUC_W-1:0] ALU_SLT = 3'b101;

  localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [SEL_W-1:0] SRC_A_PC    = 2'b00;
  localparam logic [SEL_W-1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [SEL_W-1:0] SRC_A_REG   = 2'b10;

  localparam logic [SEL_W-1:0] SRC_B_REG  = 2'b00;
  localparam logic [SEL_W-1:0] SRC_B_IMM  = 2'b01;
  localparam logic [SEL_W-1:0] SRC_B_FOUR = 2'b10;

  localparam logic [SEL_W-1:0] RES_ALUOUT = 2'b00;
  localparam logic [SEL_W-1:0] RES_DATA   = 2'b01;
  localparam logic [SEL_W-1:0] RES_ALU    = 2'b10;

  localparam logic ADR_PC     = 1'b0;
  localparam logic ADR_RESULT = 1'b1;

  // Control word driven to the datapath (everything except alu_control).
  typedef struct packed {
    logic             pc_write;
    logic             adr_src;
    logic             mem_write;
    logic             ir_write;
    logic [SEL_W-1:0] result_src;
    logic [SEL_W-1:0] alu_src_a;
    logic [SEL_W-1:0] alu_src_b;
    logic [SEL_W-1:0] imm_src;
    logic             reg_write;
    logic             illegal;
  } ctrl_t;

  function automatic logic is_store(input logic [OP_W-1:0] op);
    return op == OP_SW;
  endfunction

endpackage

// File: rtl/alu_dec.sv
// ALU operation decoder: maps the FSM's alu_op plus instruction funct
// fields onto the ALU control encoding.
module alu_dec
  import rv_ctrl_pkg::*;
(
  input  logic [SEL_W-1:0]  alu_op,
  input  logic [F3_W-1:0]   funct3,
  input  logic              funct7b5,
  input  logic              op5,
  output logic [ALUC_W-1:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // sub only for R-type; I-type bit 30 belongs to the immediate
          3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle RISC-V control unit: Moore FSM over a shared ALU/memory
// datapath with a memory-ready handshake and a retired-instruction counter.
module mc_ctrl
  import rv_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [OP_W-1:0]   op,
  input  logic [F3_W-1:0]   funct3,
  input  logic              funct7b5,
  input  logic              zero,
  input  logic              mem_ready,
  output logic              pc_write,
  output logic              adr_src,
  output logic              mem_write,
  output logic              ir_write,
  output logic [SEL_W-1:0]  result_src,
  output logic [SEL_W-1:0]  alu_src_a,
  output logic [SEL_W-1:0]  alu_src_b,
  output logic [SEL_W-1:0]  imm_src,
  output logic [ALUC_W-1:0] alu_control,
  output logic              reg_write,
  output logic              illegal,
  output logic [CNT_W-1:0]  instr_count
);

  state_t             state;
  state_t             state_n;
  ctrl_t              ctrl;
  logic [SEL_W-1:0]   alu_op;
  logic               pc_update;
  logic               branch;
  logic               retire;
  logic [CNT_W-1:0]   instr_count_q;

  // State register and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_FETCH;
      instr_count_q <= '0;
    end else begin
      state <= state_n;
      if (retire) instr_count_q <= instr_count_q + CNT_W'(1);
    end
  end

  // Next-state and control decode from the current state.
  always_comb begin
    state_n   = state;
    ctrl      = '0;
    alu_op    = ALUOP_ADD;
    pc_update = 1'b0;
    branch    = 1'b0;
    retire    = 1'b0;

    case (state)
      S_FETCH: begin
        ctrl.adr_src    = ADR_PC;
        ctrl.alu_src_a  = SRC_A_PC;
        ctrl.alu_src_b  = SRC_B_FOUR;
        ctrl.result_src = RES_ALU;
        if (mem_ready) begin
          ctrl.ir_write = 1'b1;
          pc_update     = 1'b1;
          state_n       = S_DECODE;
        end
      end

      S_DECODE: begin
        // Branch target is precomputed into ALUOut here.
        ctrl.alu_src_a = SRC_A_OLDPC;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.imm_src   = IMM_B;
        case (op)
          OP_LW, OP_SW: state_n = S_MEMADR;
          OP_R:         state_n = S_EXECR;
          OP_I:         state_n = S_EXECI;
          OP_JAL:       state_n = S_JAL;
          OP_BEQ:       state_n = S_BEQ;
          default: begin
            ctrl.illegal = 1'b1;
            state_n      = S_FETCH;
          end
        endcase
      end

      S_MEMADR: begin
        ctrl.alu_src_a = SRC_A_REG;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.imm_src   = is_store(op) ? IMM_S : IMM_I;
        state_n        = is_store(op) ? S_MEMWRITE : S_MEMREAD;
      end

      S_MEMREAD: begin
        ctrl.adr_src    = ADR_RESULT;
        ctrl.result_src = RES_ALUOUT;
        if (mem_ready) state_n = S_MEMWB;
      end

      S_MEMWB: begin
        ctrl.result_src = RES_DATA;
        ctrl.reg_write  = 1'b1;
        retire          = 1'b1;
        state_n         = S_FETCH;
      end

      S_MEMWRITE: begin
        ctrl.adr_src    = ADR_RESULT;
        ctrl.result_src = RES_ALUOUT;
        ctrl.mem_write  = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_n = S_FETCH;
        end
      end

      S_EXECR: begin
        ctrl.alu_src_a = SRC_A_REG;
        ctrl.alu_src_b = SRC_B_REG;
        alu_op         = ALUOP_FUNCT;
        state_n        = S_ALUWB;
      end

      S_EXECI: begin
        ctrl.alu_src_a = SRC_A_REG;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.imm_src   = IMM_I;
        alu_op         = ALUOP_FUNCT;
        state_n        = S_ALUWB;
      end

      S_JAL: begin
        ctrl.alu_src_a  = SRC_A_OLDPC;
        ctrl.alu_src_b  = SRC_B_FOUR;
        ctrl.result_src = RES_ALUOUT;
        ctrl.imm_src    = IMM_J;
        pc_update       = 1'b1;
        state_n         = S_ALUWB;
      end

      S_ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_write  = 1'b1;
        retire          = 1'b1;
        state_n         = S_FETCH;
      end

      S_BEQ: begin
        ctrl.alu_src_a  = SRC_A_REG;
        ctrl.alu_src_b  = SRC_B_REG;
        ctrl.result_src = RES_ALUOUT;
        ctrl.imm_src    = IMM_B;
        alu_op          = ALUOP_SUB;
        branch          = 1'b1;
        retire          = 1'b1;
        state_n         = S_FETCH;
      end

      default: state_n = S_FETCH;
    endcase

    ctrl.pc_write = pc_update | (branch & zero);

    // Reset aborts the instruction without letting any strobe escape.
    if (reset) begin
      ctrl.pc_write  = 1'b0;
      ctrl.ir_write  = 1'b0;
      ctrl.mem_write = 1'b0;
      ctrl.reg_write = 1'b0;
      ctrl.illegal   = 1'b0;
    end
  end

  alu_dec u_alu_dec (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (op[5]),
    .alu_control (alu_control)
  );

  assign pc_write    = ctrl.pc_write;
  assign adr_src     = ctrl.adr_src;
  assign mem_write   = ctrl.mem_write;
  assign ir_write    = ctrl.ir_write;
  assign result_src  = ctrl.result_src;
  assign alu_src_a   = ctrl.alu_src_a;
  assign alu_src_b   = ctrl.alu_src_b;
  assign imm_src     = ctrl.imm_src;
  assign reg_write   = ctrl.reg_write;
  assign illegal     = ctrl.illegal;
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: walks each instruction class through the FSM
// and compares the full control word against hand-computed vectors.
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic        zero;
  logic        mem_ready;
  logic        pc_write;
  logic        adr_src;
  logic        mem_write;
  logic        ir_write;
  logic [1:0]  result_src;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  imm_src;
  logic [2:0]  alu_control;
  logic        reg_write;
  logic        illegal;
  logic [31:0] instr_count;

  int unsigned passed = 0;
  int unsigned total  = 0;
  logic [31:0] exp_cnt;

  // {pc_write, adr_src, mem_write, ir_write, result_src, a, b, imm_src, alu_control, reg_write, illegal}
  logic [16:0] obs;
  assign obs = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                alu_src_b, imm_src, alu_control, reg_write, illegal};

  localparam logic [16:0] V_FETCH      = {1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 1'b0, 1'b0};
  localparam logic [16:0] V_FETCH_IDLE = {1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 1'b0, 1'b0};
  localparam logic [16:0] V_DECODE     = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b10, 3'b000, 1'b0, 1'b0};
  localparam logic [16:0] V_ILLEGAL    = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b10, 3'b000, 1'b0, 1'b1};
  localparam logic [16:0] V_EXECR_SUB  = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001, 1'b0, 1'b0};
  localparam logic [16:0] V_ALUWB      = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1, 1'b0};
  localparam logic [16:0] V_MEMADR_LW  = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 1'b0, 1'b0};
  localparam logic [16:0] V_MEMADR_SW  = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 1'b0, 1'b0};
  localparam logic [16:0] V_MEMREAD    = {1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0};
  localparam logic [16:0] V_MEMWB      = {1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1, 1'b0};
  localparam logic [16:0] V_MEMWRITE   = {1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0};
  localparam logic [16:0] V_MEMWR_RST  = {1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0};
  localparam logic [16:0] V_JAL        = {1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000, 1'b0, 1'b0};
  localparam logic [16:0] V_BEQ_TAKEN  = {1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 1'b0, 1'b0};
  localparam logic [16:0] V_BEQ_NOT    = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 1'b0, 1'b0};

  mc_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .op          (op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .pc_write    (pc_write),
    .adr_src     (adr_src),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .result_src  (result_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .imm_src     (imm_src),
    .alu_control (alu_control),
    .reg_write   (reg_write),
    .illegal     (illegal),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_ready = 1'b1; zero = 1'b0;
    op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
    tick();
    tick();
    total++; if (obs !== V_FETCH_IDLE) $display("FAIL reset_strobes: got %h want %h", obs, V_FETCH_IDLE); else passed++;
    total++; if (instr_count !== 32'd0) $display("FAIL reset_count: got %0d want 0", instr_count); else passed++;
    reset = 1'b0;
    #1;
    total++; if (obs !== V_FETCH) $display("FAIL r_fetch: got %h want %h", obs, V_FETCH); else passed++;
    tick();
    total++; if (obs !== V_DECODE) $display("FAIL r_decode: got %h want %h", obs, V_DECODE); else passed++;
    tick();
    total++; if (obs !== V_EXECR_SUB) $display("FAIL r_execr_sub: got %h want %h", obs, V_EXECR_SUB); else passed++;
    tick();
    total++; if (obs !== V_ALUWB) $display("FAIL r_aluwb: got %h want %h", obs, V_ALUWB); else passed++;
    tick();
    exp_cnt = 32'd1;
    total++; if (instr_count !== exp_cnt) $display("FAIL r_count: got %0d want %0d", instr_count, exp_cnt); else passed++;
    total++; if (obs !== V_FETCH) $display("FAIL r_back_fetch: got %h want %h", obs, V_FETCH); else passed++;
  endtask

  task automatic test_lw_wait();
    op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; mem_ready = 1'b0;
    #1;
    total++; if (obs !== V_FETCH_IDLE) $display("FAIL fetch_wait: got %h want %h", obs, V_FETCH_IDLE); else passed++;
    tick();
    total++; if (obs !== V_FETCH_IDLE) $display("FAIL fetch_hold: got %h want %h", obs, V_FETCH_IDLE); else passed++;
    mem_ready = 1'b1;
    #1;
    total++; if (obs !== V_FETCH) $display("FAIL lw_fetch: got %h want %h", obs, V_FETCH); else passed++;
    tick();
    total++; if (obs !== V_DECODE) $display("FAIL lw_decode: got %h want %h", obs, V_DECODE); else passed++;
    tick();
    total++; if (obs !== V_MEMADR_LW) $display("FAIL lw_memadr: got %h want %h", obs, V_MEMADR_LW); else passed++;
    tick();
    mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      total++; if (obs !== V_MEMREAD) $display("FAIL lw_memread_wait%0d: got %h want %h", i, obs, V_MEMREAD); else passed++;
      tick();
    end
    mem_ready = 1'b1;
    #1;
    total++; if (obs !== V_MEMREAD) $display("FAIL lw_memread_ready: got %h want %h", obs, V_MEMREAD); else passed++;
    tick();
    total++; if (obs !== V_MEMWB) $display("FAIL lw_memwb: got %h want %h", obs, V_MEMWB); else passed++;
    tick();
    exp_cnt = exp_cnt + 32'd1;
    total++; if (instr_count !== exp_cnt) $display("FAIL lw_count: got %0d want %0d", instr_count, exp_cnt); else passed++;
    total++; if (obs !== V_FETCH) $display("FAIL lw_back_fetch: got %h want %h", obs, V_FETCH); else passed++;
  endtask

  task automatic test_alu_decode();
    logic [6:0]  t_op  [6] = '{7'b0010011, 7'b0010011, 7'b0110011, 7'b0110011, 7'b0010011, 7'b0110011};
    logic [2:0]  t_f3  [6] = '{3'b000, 3'b110, 3'b010, 3'b111, 3'b001, 3'b000};
    logic        t_f7  [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [2:0]  t_alu [6] = '{3'b000, 3'b011, 3'b101, 3'b010, 3'b000, 3'b000};
    logic [1:0]  t_b   [6] = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00};
    logic [16:0] want;
    for (int i = 0; i < 6; i++) begin
      op = t_op[i]; funct3 = t_f3[i]; funct7b5 = t_f7[i]; mem_ready = 1'b1;
      want = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, t_b[i], 2'b00, t_alu[i], 1'b0, 1'b0};
      tick();
      tick();
      total++; if (obs !== want) $display("FAIL alu_exec%0d: got %h want %h", i, obs, want); else passed++;
      tick();
      tick();
      exp_cnt = exp_cnt + 32'd1;
    end
    total++; if (instr_count !== exp_cnt) $display("FAIL alu_count: got %0d want %0d", instr_count, exp_cnt); else passed++;
  endtask

  task automatic test_beq();
    op = 7'b1100011; funct3 = 3'b000; funct7b5 = 1'b0; mem_ready = 1'b1; zero = 1'b1;
    tick();
    total++; if (obs !== V_DECODE) $display("FAIL beq_decode: got %h want %h", obs, V_DECODE); else passed++;
    tick();
    total++; if (obs !== V_BEQ_TAKEN) $display("FAIL beq_taken: got %h want %h", obs, V_BEQ_TAKEN); else passed++;
    tick();
    exp_cnt = exp_cnt + 32'd1;
    total++; if (instr_count !== exp_cnt) $display("FAIL beq_taken_count: got %0d want %0d", instr_count, exp_cnt); else passed++;
    zero = 1'b0;
    tick();
    tick();
    total++; if (obs !== V_BEQ_NOT) $display("FAIL beq_not_taken: got %h want %h", obs, V_BEQ_NOT); else passed++;
    tick();
    exp_cnt = exp_cnt + 32'd1;
    total++; if (instr_count !== exp_cnt) $display("FAIL beq_not_count: got %0d want %0d", instr_count, exp_cnt); else passed++;
  endtask

  task automatic test_jal();
    op = 7'b1101111; funct3 = 3'b000; mem_ready = 1'b1;
    tick();
    tick();
    total++; if (obs !== V_JAL) $display("FAIL jal_state: got %h want %h", obs, V_JAL); else passed++;
    tick();
    total++; if (obs !== V_ALUWB) $display("FAIL jal_aluwb: got %h want %h", obs, V_ALUWB); else passed++;
    tick();
    exp_cnt = exp_cnt + 32'd1;
    total++; if (instr_count !== exp_cnt) $display("FAIL jal_count: got %0d want %0d", instr_count, exp_cnt); else passed++;
  endtask

  task automatic test_illegal();
    op = 7'b1111111; mem_ready = 1'b1;
    tick();
    total++; if (obs !== V_ILLEGAL) $display("FAIL illegal_decode: got %h want %h", obs, V_ILLEGAL); else passed++;
    tick();
    total++; if (obs !== V_FETCH) $display("FAIL illegal_back_fetch: got %h want %h", obs, V_FETCH); else passed++;
    total++; if (instr_count !== exp_cnt) $display("FAIL illegal_count: got %0d want %0d", instr_count, exp_cnt); else passed++;
  endtask

  task automatic test_sw_reset();
    op = 7'b0100011; funct3 = 3'b010; mem_ready = 1'b1;
    tick();
    tick();
    total++; if (obs !== V_MEMADR_SW) $display("FAIL sw_memadr: got %h want %h", obs, V_MEMADR_SW); else passed++;
    tick();
    total++; if (obs !== V_MEMWRITE) $display("FAIL sw_memwrite: got %h want %h", obs, V_MEMWRITE); else passed++;
    tick();
    exp_cnt = exp_cnt + 32'd1;
    total++; if (instr_count !== exp_cnt) $display("FAIL sw_count: got %0d want %0d", instr_count, exp_cnt); else passed++;
    tick();
    tick();
    tick();
    mem_ready = 1'b0;
    #1;
    total++; if (obs !== V_MEMWRITE) $display("FAIL sw_wait: got %h want %h", obs, V_MEMWRITE); else passed++;
    tick();
    total++; if (obs !== V_MEMWRITE) $display("FAIL sw_wait_hold: got %h want %h", obs, V_MEMWRITE); else passed++;
    reset = 1'b1;
    #1;
    total++; if (obs !== V_MEMWR_RST) $display("FAIL sw_reset_strobe: got %h want %h", obs, V_MEMWR_RST); else passed++;
    tick();
    reset = 1'b0; mem_ready = 1'b1;
    #1;
    exp_cnt = 32'd0;
    total++; if (obs !== V_FETCH) $display("FAIL sw_reset_fetch: got %h want %h", obs, V_FETCH); else passed++;
    total++; if (instr_count !== exp_cnt) $display("FAIL sw_reset_count: got %0d want %0d", instr_count, exp_cnt); else passed++;
  endtask

  task automatic test_wrap();
    op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0; mem_ready = 1'b1;
    tick();
    tick();
    tick();
    force dut.instr_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.instr_count_q;
    #1;
    total++; if (instr_count !== 32'hFFFF_FFFF) $display("FAIL wrap_preload: got %h want ffffffff", instr_count); else passed++;
    tick();
    total++; if (instr_count !== 32'd0) $display("FAIL wrap_count: got %h want 00000000", instr_count); else passed++;
  endtask

  initial begin
    exp_cnt = 32'd0;
    test_reset();
    test_lw_wait();
    test_alu_decode();
    test_beq();
    test_jal();
    test_illegal();
    test_sw_reset();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
